// File: rtl/ram_port_arbiter_pkg.sv
// Shared constants and owner encoding for the data-RAM port arbiter.
// The owner tag records which requester a pending RAM read belongs to.
package ram_port_arbiter_pkg;

    localparam int ADDR_W_DEF      = 10;
    localparam int DATA_W_DEF      = 32;
    localparam int MAX_CPU_RUN_DEF = 4;
    localparam int CNT_W           = 4;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DISP = 2'd2
    } owner_t;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Bundle of the CPU, display and RAM-side signals around the arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface ram_port_arbiter_if #(
    parameter int ADDR_W = ram_port_arbiter_pkg::ADDR_W_DEF,
    parameter int DATA_W = ram_port_arbiter_pkg::DATA_W_DEF
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;
    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic              disp_gnt;
    logic              disp_rvalid;
    logic [DATA_W-1:0] disp_rdata;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_din;
    logic [DATA_W-1:0] ram_dout;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, disp_req, disp_addr, ram_dout,
        output cpu_gnt, cpu_rvalid, cpu_rdata, disp_gnt, disp_rvalid, disp_rdata,
               ram_addr, ram_we, ram_din
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, disp_req, disp_addr, ram_dout,
        input  cpu_gnt, cpu_rvalid, cpu_rdata, disp_gnt, disp_rvalid, disp_rdata,
               ram_addr, ram_we, ram_din
    );
endinterface

// File: rtl/ram_port_arbiter_rr_starve_counter.sv
// Counts consecutive CPU grants while the display waits and forces a
// display slot once the CPU has used MAX_CPU_RUN of them.
module rr_starve_counter
    import ram_port_arbiter_pkg::*;
#(
    parameter int MAX_CPU_RUN = MAX_CPU_RUN_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic cpu_gnt,
    input  logic disp_gnt,
    input  logic disp_req,
    output logic force_disp
);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_CPU_RUN);

    logic [CNT_W-1:0] run_cnt;

    // The run only counts while the display is actually being held off.
    always_ff @(posedge clk) begin
        if (rst) begin
            run_cnt <= '0;
        end else if (disp_gnt || !disp_req) begin
            run_cnt <= '0;
        end else if (cpu_gnt && (run_cnt != MAX_CNT)) begin
            run_cnt <= run_cnt + 1'b1;
        end
    end

    assign force_disp = (run_cnt == MAX_CNT);

endmodule

// File: rtl/ram_port_arbiter.sv
// Single-port data RAM arbiter: fixed CPU priority with a bounded display
// starvation guarantee, and routing of 1-cycle-latency read data to its owner.
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int MAX_CPU_RUN = MAX_CPU_RUN_DEF
) (
    input logic               clk,
    input logic               rst,
    ram_port_arbiter_if.slave bus
);
    logic              cpu_gnt;
    logic              disp_gnt;
    logic              force_disp;
    logic              rd_cpu;
    logic              rd_disp;
    owner_t            rd_owner;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] disp_rdata_q;

    rr_starve_counter #(.MAX_CPU_RUN(MAX_CPU_RUN)) u_starve (
        .clk       (clk),
        .rst       (rst),
        .cpu_gnt   (cpu_gnt),
        .disp_gnt  (disp_gnt),
        .disp_req  (bus.disp_req),
        .force_disp(force_disp)
    );

    always_comb begin
        cpu_gnt  = 1'b0;
        disp_gnt = 1'b0;
        if (!rst) begin
            if (bus.cpu_req && !(bus.disp_req && force_disp)) begin
                cpu_gnt = 1'b1;
            end else if (bus.disp_req) begin
                disp_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        bus.ram_addr = '0;
        bus.ram_we   = 1'b0;
        bus.ram_din  = '0;
        if (cpu_gnt) begin
            bus.ram_addr = bus.cpu_addr;
            bus.ram_we   = bus.cpu_we;
            bus.ram_din  = bus.cpu_wdata;
        end else if (disp_gnt) begin
            bus.ram_addr = bus.disp_addr;
        end
    end

    // Tag each granted read so the data arriving next cycle finds its owner.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_owner <= OWN_NONE;
        end else if (cpu_gnt && !bus.cpu_we) begin
            rd_owner <= OWN_CPU;
        end else if (disp_gnt) begin
            rd_owner <= OWN_DISP;
        end else begin
            rd_owner <= OWN_NONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_rdata_q  <= '0;
            disp_rdata_q <= '0;
        end else begin
            if (rd_owner == OWN_CPU)  cpu_rdata_q  <= bus.ram_dout;
            if (rd_owner == OWN_DISP) disp_rdata_q <= bus.ram_dout;
        end
    end

    // A reset in the return cycle discards the pending read entirely.
    assign rd_cpu  = (rd_owner == OWN_CPU)  && !rst;
    assign rd_disp = (rd_owner == OWN_DISP) && !rst;

    assign bus.cpu_gnt     = cpu_gnt;
    assign bus.disp_gnt    = disp_gnt;
    assign bus.cpu_rvalid  = rd_cpu;
    assign bus.disp_rvalid = rd_disp;
    assign bus.cpu_rdata   = rd_cpu  ? bus.ram_dout : (rst ? '0 : cpu_rdata_q);
    assign bus.disp_rdata  = rd_disp ? bus.ram_dout : (rst ? '0 : disp_rdata_q);

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: directed scenarios plus a
// randomized run compared against an array-based model of the shared RAM.
module tb_ram_port_arbiter;
    import ram_port_arbiter_pkg::*;

    localparam int AW   = 10;
    localparam int DW   = 32;
    localparam int MAXR = 4;
    localparam logic [DW-1:0] VAL_A = 32'h1234_5678;
    localparam logic [DW-1:0] VAL_B = 32'h9ABC_DEF0;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_CPU_RUN(MAXR)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Behavioural single-port RAM with one-cycle synchronous read.
    logic [DW-1:0] ram [1<<AW] = '{default: '0};
    always @(posedge clk) begin
        if (bus.ram_we) ram[bus.ram_addr] <= bus.ram_din;
        bus.ram_dout <= ram[bus.ram_addr];
    end

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic [DW-1:0] mdl_mem [1<<AW] = '{default: '0};
    int            mdl_run   = 0;
    bit            pend_cpu  = 0;
    bit            pend_disp = 0;
    logic [DW-1:0] pend_data = '0;
    logic [DW-1:0] held_cpu  = '0;
    logic [DW-1:0] held_disp = '0;

    bit            cur_rst, cur_cw, cur_dr;
    logic [AW-1:0] cur_ca;
    logic [DW-1:0] cur_cd;

    bit            exp_cg, exp_dg, exp_we, exp_cv, exp_dv;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_din, exp_cd, exp_dd;

    task automatic drive(input bit r, input bit cr, input bit cw, input logic [AW-1:0] ca,
                         input logic [DW-1:0] cd, input bit dr, input logic [AW-1:0] da);
        rst = r;
        bus.cpu_req = cr;  bus.cpu_we = cw;  bus.cpu_addr = ca;  bus.cpu_wdata = cd;
        bus.disp_req = dr; bus.disp_addr = da;
        cur_rst = r; cur_cw = cw; cur_ca = ca; cur_cd = cd; cur_dr = dr;
        exp_cg = 0;
        exp_dg = 0;
        if (!r) begin
            if (cr && !(dr && mdl_run >= MAXR)) exp_cg = 1;
            else if (dr) exp_dg = 1;
        end
        exp_we   = exp_cg && cw;
        exp_addr = exp_cg ? ca : (exp_dg ? da : '0);
        exp_din  = exp_cg ? cd : '0;
        exp_cv   = !r && pend_cpu;
        exp_dv   = !r && pend_disp;
        exp_cd   = r ? '0 : (pend_cpu  ? pend_data : held_cpu);
        exp_dd   = r ? '0 : (pend_disp ? pend_data : held_disp);
        #1;
    endtask

    task automatic tick();
        if (cur_rst) begin
            mdl_run = 0; pend_cpu = 0; pend_disp = 0; held_cpu = '0; held_disp = '0;
        end else begin
            if (pend_cpu)  held_cpu  = pend_data;
            if (pend_disp) held_disp = pend_data;
            pend_cpu  = exp_cg && !cur_cw;
            pend_disp = exp_dg;
            if (exp_cg || exp_dg) pend_data = mdl_mem[exp_addr];
            if (exp_we) mdl_mem[cur_ca] = cur_cd;
            if (exp_dg || !cur_dr) mdl_run = 0;
            else if (exp_cg) mdl_run = (mdl_run + 1 > MAXR) ? MAXR : mdl_run + 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(1, 1, 1, 10'h3FF, 32'hFFFF_FFFF, 1, 10'h155);
        checks++; if (bus.cpu_gnt !== 1'b0) begin errors++; $display("[TB] FAIL rst_cpu_gnt got %0b exp 0", bus.cpu_gnt); end
        checks++; if (bus.disp_gnt !== 1'b0) begin errors++; $display("[TB] FAIL rst_disp_gnt got %0b exp 0", bus.disp_gnt); end
        checks++; if (bus.ram_we !== 1'b0) begin errors++; $display("[TB] FAIL rst_ram_we got %0b exp 0", bus.ram_we); end
        checks++; if (bus.ram_addr !== '0) begin errors++; $display("[TB] FAIL rst_ram_addr got %h exp 0", bus.ram_addr); end
        checks++; if (bus.cpu_rdata !== '0 || bus.cpu_rvalid !== 1'b0) begin errors++; $display("[TB] FAIL rst_cpu_ret got %0b/%h exp 0/0", bus.cpu_rvalid, bus.cpu_rdata); end
        checks++; if (bus.disp_rdata !== '0 || bus.disp_rvalid !== 1'b0) begin errors++; $display("[TB] FAIL rst_disp_ret got %0b/%h exp 0/0", bus.disp_rvalid, bus.disp_rdata); end
        tick();
        drive(0, 0, 0, 10'h3FF, '0, 0, 10'h155);
        checks++; if (bus.cpu_gnt !== 1'b0 || bus.disp_gnt !== 1'b0 || bus.ram_addr !== '0) begin errors++; $display("[TB] FAIL idle_outputs got %0b/%0b/%h exp 0/0/0", bus.cpu_gnt, bus.disp_gnt, bus.ram_addr); end
        tick();
    endtask

    task automatic test_cpu_write_read();
        drive(0, 1, 1, 10'h005, 32'hDEAD_BEEF, 0, '0);
        checks++; if (bus.cpu_gnt !== 1'b1 || bus.ram_we !== 1'b1) begin errors++; $display("[TB] FAIL wr_gnt_we got %0b/%0b exp 1/1", bus.cpu_gnt, bus.ram_we); end
        checks++; if (bus.ram_addr !== 10'h005 || bus.ram_din !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL wr_bus got %h/%h exp 005/deadbeef", bus.ram_addr, bus.ram_din); end
        tick();
        drive(0, 1, 0, 10'h005, 32'h0BAD_0BAD, 0, '0);
        checks++; if (bus.cpu_gnt !== 1'b1 || bus.ram_we !== 1'b0) begin errors++; $display("[TB] FAIL rd_gnt_we got %0b/%0b exp 1/0", bus.cpu_gnt, bus.ram_we); end
        checks++; if (bus.cpu_rvalid !== 1'b0) begin errors++; $display("[TB] FAIL wr_no_rvalid got %0b exp 0", bus.cpu_rvalid); end
        tick();
        drive(0, 0, 0, '0, '0, 0, '0);
        checks++; if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL rd_return got %0b/%h exp 1/deadbeef", bus.cpu_rvalid, bus.cpu_rdata); end
        checks++; if (bus.disp_rvalid !== 1'b0) begin errors++; $display("[TB] FAIL rd_no_disp got %0b exp 0", bus.disp_rvalid); end
        tick();
    endtask

    task automatic test_disp_read();
        drive(0, 0, 0, '0, '0, 1, 10'h005);
        checks++; if (bus.disp_gnt !== 1'b1 || bus.cpu_gnt !== 1'b0 || bus.ram_we !== 1'b0) begin errors++; $display("[TB] FAIL disp_gnt got %0b/%0b/%0b exp 1/0/0", bus.disp_gnt, bus.cpu_gnt, bus.ram_we); end
        checks++; if (bus.ram_addr !== 10'h005) begin errors++; $display("[TB] FAIL disp_addr got %h exp 005", bus.ram_addr); end
        tick();
        drive(0, 0, 0, '0, '0, 0, '0);
        checks++; if (bus.disp_rvalid !== 1'b1 || bus.disp_rdata !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL disp_return got %0b/%h exp 1/deadbeef", bus.disp_rvalid, bus.disp_rdata); end
        checks++; if (bus.cpu_rvalid !== 1'b0 || bus.cpu_rdata !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL cpu_hold got %0b/%h exp 0/deadbeef", bus.cpu_rvalid, bus.cpu_rdata); end
        tick();
    endtask

    task automatic test_starvation();
        bit want_d;
        for (int i = 0; i < 10; i++) begin
            drive(0, 1, 0, AW'($urandom_range(0, 63)), '0, 1, AW'($urandom_range(0, 63)));
            want_d = ((i % (MAXR + 1)) == MAXR);
            checks++;
            if (bus.disp_gnt !== want_d || bus.cpu_gnt !== !want_d) begin
                errors++; $display("[TB] FAIL starve_pattern[%0d] got c%0b/d%0b exp c%0b/d%0b", i, bus.cpu_gnt, bus.disp_gnt, !want_d, want_d);
            end
            tick();
        end
        drive(0, 0, 0, '0, '0, 0, '0);
        tick();
    endtask

    task automatic test_back_to_back();
        drive(0, 1, 1, 10'h010, VAL_A, 0, '0); tick();
        drive(0, 1, 1, 10'h011, VAL_B, 0, '0); tick();
        drive(0, 1, 0, 10'h010, '0, 1, 10'h011);
        checks++; if (bus.cpu_gnt !== 1'b1 || bus.disp_gnt !== 1'b0) begin errors++; $display("[TB] FAIL b2b_first got c%0b/d%0b exp c1/d0", bus.cpu_gnt, bus.disp_gnt); end
        tick();
        drive(0, 0, 0, '0, '0, 1, 10'h011);
        checks++; if (bus.disp_gnt !== 1'b1) begin errors++; $display("[TB] FAIL b2b_second got %0b exp 1", bus.disp_gnt); end
        checks++; if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== VAL_A) begin errors++; $display("[TB] FAIL b2b_cpu_data got %0b/%h exp 1/%h", bus.cpu_rvalid, bus.cpu_rdata, VAL_A); end
        tick();
        drive(0, 0, 0, '0, '0, 0, '0);
        checks++; if (bus.disp_rvalid !== 1'b1 || bus.disp_rdata !== VAL_B || bus.cpu_rvalid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_disp_data got %0b/%h/%0b exp 1/%h/0", bus.disp_rvalid, bus.disp_rdata, bus.cpu_rvalid, VAL_B); end
        tick();
    endtask

    task automatic test_reset_after_read();
        bit want_d;
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, 10'h010, '0, 1, 10'h011);
            checks++; if (bus.cpu_gnt !== 1'b1) begin errors++; $display("[TB] FAIL pre_rst_gnt[%0d] got %0b exp 1", i, bus.cpu_gnt); end
            tick();
        end
        drive(1, 1, 0, 10'h010, '0, 1, 10'h011);
        checks++; if (bus.cpu_rvalid !== 1'b0 || bus.cpu_rdata !== '0) begin errors++; $display("[TB] FAIL rst_discard got %0b/%h exp 0/0", bus.cpu_rvalid, bus.cpu_rdata); end
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, 0, 10'h010, '0, 1, 10'h011);
            want_d = (i == MAXR);
            checks++; if (bus.disp_gnt !== want_d || bus.cpu_gnt !== !want_d) begin errors++; $display("[TB] FAIL post_rst_run[%0d] got c%0b/d%0b exp c%0b/d%0b", i, bus.cpu_gnt, bus.disp_gnt, !want_d, want_d); end
            if (i == 1) begin
                checks++; if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== VAL_A) begin errors++; $display("[TB] FAIL post_rst_read got %0b/%h exp 1/%h", bus.cpu_rvalid, bus.cpu_rdata, VAL_A); end
            end
            tick();
        end
        drive(0, 0, 0, '0, '0, 0, '0);
        tick();
    endtask

    task automatic test_drop_request();
        for (int i = 0; i < MAXR; i++) begin
            drive(0, 1, 0, 10'h010, '0, 1, 10'h011);
            tick();
        end
        drive(0, 1, 1, 10'h020, 32'hCAFE_F00D, 1, 10'h011);
        checks++; if (bus.disp_gnt !== 1'b1 || bus.cpu_gnt !== 1'b0 || bus.ram_we !== 1'b0) begin errors++; $display("[TB] FAIL drop_disp_slot got d%0b/c%0b/we%0b exp 1/0/0", bus.disp_gnt, bus.cpu_gnt, bus.ram_we); end
        tick();
        drive(0, 0, 1, 10'h020, 32'hCAFE_F00D, 0, '0);
        checks++; if (bus.ram_we !== 1'b0 || bus.disp_rvalid !== 1'b1 || bus.disp_rdata !== VAL_B) begin errors++; $display("[TB] FAIL drop_disp_ret got we%0b/%0b/%h exp 0/1/%h", bus.ram_we, bus.disp_rvalid, bus.disp_rdata, VAL_B); end
        tick();
        drive(0, 1, 0, 10'h020, '0, 0, '0); tick();
        drive(0, 0, 0, '0, '0, 0, '0);
        checks++; if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== '0) begin errors++; $display("[TB] FAIL drop_no_write got %0b/%h exp 1/0", bus.cpu_rvalid, bus.cpu_rdata); end
        tick();
    endtask

    task automatic test_random();
        bit r, cr, cw, dr;
        for (int i = 0; i < 400; i++) begin
            r  = ($urandom_range(0, 31) == 0);
            cr = ($urandom_range(0, 3) != 0);
            cw = ($urandom_range(0, 2) == 0);
            dr = ($urandom_range(0, 2) != 0);
            drive(r, cr, cw, AW'($urandom_range(0, 15)), DW'($urandom), dr, AW'($urandom_range(0, 15)));
            checks++;
            if (bus.cpu_gnt !== exp_cg || bus.disp_gnt !== exp_dg || bus.ram_we !== exp_we ||
                bus.ram_addr !== exp_addr || bus.ram_din !== exp_din) begin
                errors++; $display("[TB] FAIL rand_port[%0d] got c%0b d%0b we%0b %h %h exp c%0b d%0b we%0b %h %h", i,
                    bus.cpu_gnt, bus.disp_gnt, bus.ram_we, bus.ram_addr, bus.ram_din, exp_cg, exp_dg, exp_we, exp_addr, exp_din);
            end
            checks++;
            if (bus.cpu_rvalid !== exp_cv || bus.cpu_rdata !== exp_cd || bus.disp_rvalid !== exp_dv || bus.disp_rdata !== exp_dd) begin
                errors++; $display("[TB] FAIL rand_ret[%0d] got %0b/%h %0b/%h exp %0b/%h %0b/%h", i,
                    bus.cpu_rvalid, bus.cpu_rdata, bus.disp_rvalid, bus.disp_rdata, exp_cv, exp_cd, exp_dv, exp_dd);
            end
            tick();
        end
    endtask

    initial begin
        drive(1, 0, 0, '0, '0, 0, '0);
        @(posedge clk);
        #1;
        tick();
        test_reset();
        test_cpu_write_read();
        test_disp_read();
        test_starvation();
        test_back_to_back();
        test_reset_after_read();
        test_drop_request();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
